// File: rtl/argmax_classifier_pkg.sv
// argmax_classifier_pkg: shared constants and FSM state type for the argmax classifier slice.
package argmax_classifier_pkg;
  localparam int SCORE_W_DEF = 16;
  localparam int CLS_NOISE   = 0;
  localparam int CLS_SPEECH  = 1;
  typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;
endpackage

// File: rtl/argmax_classifier_if.sv
// argmax_classifier_if: score-beat stream in, registered class decision out.
interface argmax_classifier_if
  import argmax_classifier_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int IDX_W   = 2
);
  logic                      force_en;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [SCORE_W-1:0] in_score;
  logic                      in_last;
  logic                      out_valid;
  logic [IDX_W-1:0]          out_class;
  logic signed [SCORE_W-1:0] out_score;
  logic                      out_err;
  modport master (
    output force_en, in_valid, in_score, in_last,
    input  in_ready, out_valid, out_class, out_score, out_err
  );
  modport slave (
    input  force_en, in_valid, in_score, in_last,
    output in_ready, out_valid, out_class, out_score, out_err
  );
endinterface

// File: rtl/argmax_classifier_hangover.sv
// argmax_classifier_hangover: holds the last nonzero class over up to HANG_FRAMES noise decisions.
module argmax_classifier_hangover
  import argmax_classifier_pkg::*;
#(
  parameter int IDX_W       = 2,
  parameter int HANG_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             err,
  input  logic [IDX_W-1:0] raw,
  output logic [IDX_W-1:0] cls
);
  localparam int CW = $clog2(HANG_FRAMES + 1) + 1;
  logic [CW-1:0]    hcnt;
  logic [IDX_W-1:0] last_cls;
  logic             noise;
  always_comb begin
    noise = raw == IDX_W'(CLS_NOISE);
    cls   = (!err && noise && hcnt != '0) ? last_cls : raw;
  end
  // errored frames are transparent: they neither reload nor consume the hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt     <= '0;
      last_cls <= '0;
    end else if (en && !err) begin
      if (!noise) begin
        hcnt     <= CW'(HANG_FRAMES);
        last_cls <= raw;
      end else if (hcnt != '0) begin
        hcnt <= hcnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/argmax_classifier.sv
// argmax_classifier: streaming N-way signed argmax with force override and length-error flag.
// Optional speech hangover is enabled by defining VAD_HANGOVER_EN.
module argmax_classifier
  import argmax_classifier_pkg::*;
#(
  parameter int N_CLASS     = 2,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int IDX_W       = $clog2(N_CLASS) + 1,
  parameter int HANG_FRAMES = 4
) (
  input logic clk,
  input logic rst_n,
  argmax_classifier_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);
  state_t                    state, state_nx;
  logic [IDX_W-1:0]          cnt, best_idx, win_idx, dec_class, fin_class;
  logic signed [SCORE_W-1:0] score, best_score, win_score;
  logic                      accept, at_end, upd, err, done;
  assign bus.in_ready = state != EMIT;
  // strict compare keeps the lower index on ties; IDLE means first beat of a frame
  always_comb begin
    score     = bus.in_score;
    accept    = bus.in_valid && state != EMIT;
    at_end    = bus.in_last || cnt == LAST_IDX;
    done      = accept && at_end;
    upd       = state == IDLE || score > best_score;
    win_idx   = upd ? cnt : best_idx;
    win_score = upd ? score : best_score;
    err       = !(bus.in_last && cnt == LAST_IDX);
    dec_class = bus.force_en ? LAST_IDX : win_idx;
    state_nx  = state == EMIT ? IDLE : !accept ? state : at_end ? EMIT : ACC;
  end
`ifdef VAD_HANGOVER_EN
  argmax_classifier_hangover #(
    .IDX_W      (IDX_W),
    .HANG_FRAMES(HANG_FRAMES)
  ) u_hang (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (done),
    .err  (err),
    .raw  (dec_class),
    .cls  (fin_class)
  );
`else
  logic unused_hang;
  assign unused_hang = ^HANG_FRAMES;
  assign fin_class   = dec_class;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      best_idx      <= '0;
      best_score    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_class <= '0;
      bus.out_score <= '0;
      bus.out_err   <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.out_valid <= done;
      if (accept) begin
        cnt        <= at_end ? '0 : cnt + 1'b1;
        best_idx   <= win_idx;
        best_score <= win_score;
      end
      if (done) begin
        bus.out_class <= fin_class;
        bus.out_score <= win_score;
        bus.out_err   <= err;
      end
    end
  end
endmodule
